// File: rtl/nv_ram_fifo_ctrl_256x256.sv
// Valid/ready FIFO controller over a 256x256 two-port RAM with a 2-entry output skid buffer.
// Optional macro NV_RAM_FIFO_CTRL_BYPASS_EN routes writes into an empty FIFO straight to the skid.
module nv_ram_fifo_ctrl_256x256 #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW+1:0] fifo_count,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic [31:0]   ram_pwrbus_ram_pd
);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   ram_cnt_t;
  typedef logic [AW+1:0] fifo_cnt_t;
  typedef logic [1:0]    skid_cnt_t;

  localparam ram_cnt_t RamFull = ram_cnt_t'(1) << AW;

  ptr_t          wr_ptr_q, wr_ptr_d;
  ptr_t          rd_ptr_q, rd_ptr_d;
  ram_cnt_t      ram_cnt_q, ram_cnt_d;
  logic          rd_inflight_q, rd_inflight_d;
  logic [DW-1:0] skid_mem_q [2];
  logic          skid_head_q, skid_head_d;
  logic          skid_tail_q, skid_tail_d;
  skid_cnt_t     skid_cnt_q, skid_cnt_d;
  fifo_cnt_t     fifo_count_q, fifo_count_d;

  logic          wr_fire;
  logic          pop;
  logic          rd_issue;
  logic          bypass;
  logic          push;
  logic [DW-1:0] push_data;
  skid_cnt_t     occ;

  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

  // Handshake outputs come from registered state only (plus reset gating).
  assign wr_prdy = !rst && (ram_cnt_q != RamFull);
  assign rd_pvld = (skid_cnt_q != '0);
  assign rd_pd   = skid_mem_q[skid_head_q];

  assign wr_fire = wr_pvld && wr_prdy;
  assign pop     = rd_pvld && rd_prdy;

  // Slots already spoken for in the skid: held entries plus the read returning this cycle.
  assign occ      = skid_cnt_q + skid_cnt_t'(rd_inflight_q);
  assign rd_issue = !rst && (ram_cnt_q != '0) &&
                    ((occ < skid_cnt_t'(2)) || ((occ == skid_cnt_t'(2)) && pop));

`ifdef NV_RAM_FIFO_CTRL_BYPASS_EN
  assign bypass = wr_fire && (ram_cnt_q == '0) && !rd_inflight_q &&
                  ((skid_cnt_q != skid_cnt_t'(2)) || pop);
`else
  assign bypass = 1'b0;
`endif

  assign ram_we = wr_fire && !bypass;
  assign ram_wa = wr_ptr_q;
  assign ram_di = wr_pd;
  assign ram_re = rd_issue;
  assign ram_ra = rd_ptr_q;

  // Capture and bypass are mutually exclusive: bypass requires no read in flight.
  assign push      = rd_inflight_q || bypass;
  assign push_data = bypass ? wr_pd : ram_dout;

  assign fifo_count = fifo_count_q;

  always_comb begin
    wr_ptr_d      = ram_we ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d      = rd_issue ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    rd_inflight_d = rd_issue;
    ram_cnt_d     = ram_cnt_q;
    if (ram_we && !rd_issue) begin
      ram_cnt_d = ram_cnt_q + ram_cnt_t'(1);
    end else if (!ram_we && rd_issue) begin
      ram_cnt_d = ram_cnt_q - ram_cnt_t'(1);
    end
    skid_cnt_d = skid_cnt_q;
    case ({push, pop})
      2'b10:   skid_cnt_d = skid_cnt_q + skid_cnt_t'(1);
      2'b01:   skid_cnt_d = skid_cnt_q - skid_cnt_t'(1);
      default: skid_cnt_d = skid_cnt_q;
    endcase
    skid_head_d  = pop ? ~skid_head_q : skid_head_q;
    skid_tail_d  = push ? ~skid_tail_q : skid_tail_q;
    fifo_count_d = fifo_cnt_t'(ram_cnt_d) + fifo_cnt_t'(rd_inflight_d) +
                   fifo_cnt_t'(skid_cnt_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      skid_head_q   <= 1'b0;
      skid_tail_q   <= 1'b0;
      skid_cnt_q    <= '0;
      fifo_count_q  <= '0;
      skid_mem_q[0] <= '0;
      skid_mem_q[1] <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_cnt_q     <= ram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      skid_head_q   <= skid_head_d;
      skid_tail_q   <= skid_tail_d;
      skid_cnt_q    <= skid_cnt_d;
      fifo_count_q  <= fifo_count_d;
      if (push) begin
        skid_mem_q[skid_tail_q] <= push_data;
      end
    end
  end

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_256x256.sv
// Bench for nv_ram_fifo_ctrl_256x256: RAM model plus a queue-based reference of FIFO contents.
module tb_nv_ram_fifo_ctrl_256x256;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 256;

  logic          clk;
  logic          rst;
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic [AW+1:0] fifo_count;
  logic [AW-1:0] ram_wa;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic [DW-1:0] ram_dout;
  logic [31:0]   pwrbus_ram_pd;
  logic [31:0]   ram_pwrbus_ram_pd;

  nv_ram_fifo_ctrl_256x256 #(.AW(AW), .DW(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .wr_pvld           (wr_pvld),
    .wr_prdy           (wr_prdy),
    .wr_pd             (wr_pd),
    .rd_pvld           (rd_pvld),
    .rd_prdy           (rd_prdy),
    .rd_pd             (rd_pd),
    .fifo_count        (fifo_count),
    .ram_wa            (ram_wa),
    .ram_we            (ram_we),
    .ram_di            (ram_di),
    .ram_ra            (ram_ra),
    .ram_re            (ram_re),
    .ram_dout          (ram_dout),
    .pwrbus_ram_pd     (pwrbus_ram_pd),
    .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-port RAM with registered read address.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ram_dout <= mem[ram_ra];
  end

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] q[$];

  logic          s_wprdy, s_rpvld, s_we, s_re, s_wfire, s_pop;
  logic [AW-1:0] s_wa, s_ra;
  logic [AW+1:0] s_fc;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // One clock: inputs already driven after a negedge; sample, check, update model.
  task automatic tick();
    logic [DW-1:0] exp;
    #1;
    s_wprdy = wr_prdy;
    s_rpvld = rd_pvld;
    s_we    = ram_we;
    s_re    = ram_re;
    s_wa    = ram_wa;
    s_ra    = ram_ra;
    s_fc    = fifo_count;
    s_wfire = !rst && wr_pvld && wr_prdy;
    s_pop   = !rst && rd_pvld && rd_prdy;
    chk("fifo_count", DW'(fifo_count), DW'(q.size()));
    if (rst) begin
      chk("rst_wr_prdy", DW'(wr_prdy), '0);
      chk("rst_ram_we", DW'(ram_we), '0);
      chk("rst_ram_re", DW'(ram_re), '0);
      q.delete();
    end else begin
      if (q.size() < 256) chk("wr_prdy_room", DW'(wr_prdy), DW'(1));
      if (q.size() == 258) chk("wr_prdy_full", DW'(wr_prdy), '0);
      if (q.size() == 0) chk("rd_pvld_empty", DW'(rd_pvld), '0);
      if (s_pop) begin
        exp = q.pop_front();
        chk("rd_pd", rd_pd, exp);
      end
      if (s_wfire) q.push_back(wr_pd);
    end
    @(negedge clk);
  endtask

  int n_wr, n_pop, first_pop, last_pop;
  logic [DW-1:0] a5;
  logic [DW-1:0] w_after;

  initial begin
    rst           = 1'b1;
    wr_pvld       = 1'b0;
    rd_prdy       = 1'b0;
    wr_pd         = '0;
    pwrbus_ram_pd = 32'h1234_5678;
    @(negedge clk);

    // Reset held with producer pushing.
    for (int i = 0; i < 3; i++) begin
      wr_pvld = 1'b1;
      wr_pd   = rnd_word();
      tick();
      chk("rst_rd_pvld", DW'(s_rpvld), '0);
    end
    chk("pwrbus", DW'(ram_pwrbus_ram_pd), DW'(32'h1234_5678));

    rst     = 1'b0;
    wr_pvld = 1'b0;
    tick();
    chk("post_rst_wr_prdy", DW'(s_wprdy), DW'(1));

    // Single word latency.
    a5      = {(DW / 8){8'hA5}};
    wr_pvld = 1'b1;
    wr_pd   = a5;
    rd_prdy = 1'b1;
    tick();
    wr_pvld = 1'b0;
`ifdef NV_RAM_FIFO_CTRL_BYPASS_EN
    chk("single_we_bypass", DW'(s_we), '0);
    tick();
    chk("single_pvld_c1", DW'(s_rpvld), DW'(1));
    chk("single_re_c1", DW'(s_re), '0);
`else
    chk("single_we_c0", DW'(s_we), DW'(1));
    chk("single_wa_c0", DW'(s_wa), '0);
    tick();
    chk("single_re_c1", DW'(s_re), DW'(1));
    chk("single_ra_c1", DW'(s_ra), '0);
    chk("single_pvld_c1", DW'(s_rpvld), '0);
    tick();
    chk("single_pvld_c2", DW'(s_rpvld), '0);
    tick();
    chk("single_pvld_c3", DW'(s_rpvld), DW'(1));
`endif
    tick();

    // Fill with consumer stalled.
    n_wr    = 0;
    rd_prdy = 1'b0;
    for (int t = 0; t < 400 && n_wr < 258; t++) begin
      wr_pvld = 1'b1;
      wr_pd   = DW'(n_wr);
      tick();
      if (s_wfire) n_wr++;
    end
    chk("fill_accepts", DW'(n_wr), DW'(258));
    wr_pd = rnd_word();
    tick();
    chk("full_wr_prdy", DW'(s_wprdy), '0);
    chk("full_count", DW'(s_fc), DW'(258));

    // One pop reopens the RAM one cycle later.
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    tick();
    chk("full_pop_re", DW'(s_re), DW'(1));
    chk("full_pop_wr_prdy", DW'(s_wprdy), '0);
    rd_prdy = 1'b0;
    tick();
    chk("reopen_wr_prdy", DW'(s_wprdy), DW'(1));
    rd_prdy = 1'b1;
    for (int t = 0; t < 400 && q.size() > 0; t++) tick();
    tick();
    chk("drain_count", DW'(s_fc), '0);

    // Continuous streaming, both sides ready.
    n_wr = 0; n_pop = 0; first_pop = -1; last_pop = -1;
    for (int t = 0; t < 1010; t++) begin
      wr_pvld = (n_wr < 1000);
      wr_pd   = rnd_word();
      rd_prdy = 1'b1;
      tick();
      if (s_wfire) n_wr++;
      if (s_pop) begin
        if (first_pop < 0) first_pop = t;
        last_pop = t;
        n_pop++;
      end
    end
    wr_pvld = 1'b0;
    chk("stream_writes", DW'(n_wr), DW'(1000));
    chk("stream_pops", DW'(n_pop), DW'(1000));
    chk("stream_no_bubble", DW'(last_pop - first_pop), DW'(999));
`ifdef NV_RAM_FIFO_CTRL_BYPASS_EN
    chk("stream_latency", DW'(first_pop), DW'(1));
`else
    chk("stream_latency", DW'(first_pop), DW'(3));
`endif

    // Random traffic.
    n_wr = 0;
    for (int t = 0; t < 60000 && n_wr < 10000; t++) begin
      wr_pvld = $urandom_range(0, 1) != 0;
      wr_pd   = rnd_word();
      rd_prdy = $urandom_range(0, 1) != 0;
      tick();
      if (s_wfire) n_wr++;
    end
    chk("rand_writes", DW'(n_wr), DW'(10000));
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    for (int t = 0; t < 400 && q.size() > 0; t++) tick();
    tick();
    chk("rand_drain_count", DW'(s_fc), '0);

    // Reset while a read is in flight and the skid holds data.
    rd_prdy = 1'b0;
    for (int t = 0; t < 10; t++) begin
      wr_pvld = 1'b1;
      wr_pd   = rnd_word();
      tick();
    end
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    tick();
    chk("mid_rst_re_before", DW'(s_re), DW'(1));
    rst     = 1'b1;
    wr_pvld = 1'b1;
    tick();
    tick();
    rst     = 1'b0;
    wr_pvld = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("mid_rst_no_pvld", DW'(s_rpvld), '0);
    end
    w_after = rnd_word();
    wr_pvld = 1'b1;
    wr_pd   = w_after;
    tick();
    wr_pvld = 1'b0;
    n_pop   = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (s_pop) n_pop++;
    end
    chk("mid_rst_one_word", DW'(n_pop), DW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
